window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the edge-detection stage. It accepts raster-order 24-bit RGB pixels, one per accepted cycle, and buffers the two previous image lines. For every interior pixel it emits the full 3x3 RGB window in p1..p9 order (p5 is the centre), along with the centre coordinates. Border pixels, meaning the first and last row and column, produce no window; downstream handles them.

## Interface
- IMG_WIDTH, 512: pixels per line; must be ≥ 3.
- IMG_HEIGHT, 512: lines per frame; must be ≥ 3.
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pixel is accepted this cycle. There is no backpressure: every valid pixel is accepted.
- in_pixel  in  24  RGB input pixel: [23:16] R, [15:8] G, [7:0] B.
- out_valid  out  1  window outputs are valid this cycle (single-cycle strobe per window).
- out_pixel_1..out_pixel_9  out  24 each  window pixels:
  - 1..3 are the top row (row r−1), left to right.
  - 4..6 are the middle row (row r).
  - 7..9 are the bottom row (row r+1).
- out_row  out  $clog2(IMG_HEIGHT)  centre row r.
- out_col  out  $clog2(IMG_WIDTH)  centre column c.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Input position counters:
  - col_cnt counts 0..IMG_WIDTH−1; row_cnt counts 0..IMG_HEIGHT−1.
  - Both advance only on in_valid.
  - col_cnt wraps to 0 and increments row_cnt; row_cnt wraps to 0 after the last pixel of the frame.
- Line buffers:
  - Two IMG_WIDTH-deep, 24-bit line memories.
  - LB0 holds row_cnt−1 and LB1 holds row_cnt−2.
  - On an accepted pixel at column x: read LB0[x] and LB1[x], write LB1[x] ← LB0[x], then write LB0[x] ← in_pixel (read-before-write).
  - Either register-array or inferred-BRAM implementation is acceptable, provided latency is as specified.
- Column shift registers: three 3-deep shift registers, one each for the top, middle and bottom rows.
  - Each accepted pixel shifts in {LB1[x], LB0[x], in_pixel}.
  - The newest entry becomes column c+1, i.e. pixels 3, 6 and 9.
- Window emission:
  - An accepted pixel at (row_cnt, col_cnt) with row_cnt ≥ 2 and col_cnt ≥ 2 completes the window centred at (row_cnt−1, col_cnt−1).
  - The next cycle asserts out_valid with that window, out_row = row_cnt−1 and out_col = col_cnt−1.
- Windows never straddle lines: the col_cnt ≥ 2 gate discards the stale shift contents left from the previous line.
- Output count: each frame produces exactly (IMG_WIDTH−2)·(IMG_HEIGHT−2) windows.
- frame_done asserts together with out_valid for the window centred at (IMG_HEIGHT−2, IMG_WIDTH−2).
- in_valid gaps: all state holds; out_valid is low in every cycle that does not follow an accepted completing pixel.
- Outputs hold their last values while out_valid is low.
- Frames are back-to-back. Pixel (0,0) of the next frame may arrive in the cycle immediately after the last pixel. No windows are emitted until row 2 of the new frame, so stale line-buffer data is never output.

## Timing
- Reset values: all outputs 0; col_cnt = row_cnt = 0; shift registers 0. Line-buffer contents are don't-care and need no clearing.
- Latency: exactly 1 clk from acceptance of the completing pixel to out_valid.
- Throughput: one window per clock with in_valid held high.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronously).
  - After deassertion, the next accepted pixel is treated as (0,0).
  - No window appears before 2·IMG_WIDTH+3 accepted pixels.
- in_valid sampled while rst_n is low is ignored.

## Test plan
All scenarios use IMG_WIDTH=5 and IMG_HEIGHT=4. Pixel (r,c) = {8'(r), 8'(c), 8'(16r+c)}.

- Continuous frame, in_valid held high:
  - First out_valid occurs 1 cycle after the 13th accepted pixel (2,2): out_row=1, out_col=1, out_pixel_1=24'h000000, out_pixel_5=24'h010111, out_pixel_9=24'h020222.
  - Total of 6 windows; frame_done coincides with the window at centre (2,3), whose out_pixel_9 = 24'h030434.
- Line boundary: no out_valid follows acceptance of pixels (2,0), (2,1), (3,0) or (3,1).
  - The window at centre (2,1) has out_pixel_1 = 24'h010010, out_pixel_3 = 24'h010212 and out_pixel_7 = 24'h030030.
- Random in_valid gaps (~50% duty):
  - Window contents and order are identical to the continuous case.
  - out_valid is always exactly 1 cycle after the completing pixel.
  - Outputs are stable between strobes.
- Back-to-back frames: two frames with no gap give 12 windows and 2 frame_done pulses.
  - Second-frame windows carry no first-frame data: its first window again has out_pixel_1 = 24'h000000.
- Reset mid-frame: assert rst_n=0 after 9 pixels; all outputs read 0 during reset.
  - After release, a full frame gives exactly 6 correct windows.
  - The first window follows the 13th post-reset pixel.

Source files
------------

// File: rtl/window_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 neighbourhood generator.
// The master drives the raster stream and receives windows; the slave is the generator.
interface window_3x3_if #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 24
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic              in_valid;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic [DATA_W-1:0] out_pixel_1, out_pixel_2, out_pixel_3;
    logic [DATA_W-1:0] out_pixel_4, out_pixel_5, out_pixel_6;
    logic [DATA_W-1:0] out_pixel_7, out_pixel_8, out_pixel_9;
    logic [RW-1:0]     out_row;
    logic [CW-1:0]     out_col;
    logic              frame_done;

    modport master (
        output in_valid, in_pixel,
        input  out_valid, out_pixel_1, out_pixel_2, out_pixel_3,
               out_pixel_4, out_pixel_5, out_pixel_6,
               out_pixel_7, out_pixel_8, out_pixel_9,
               out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output out_valid, out_pixel_1, out_pixel_2, out_pixel_3,
               out_pixel_4, out_pixel_5, out_pixel_6,
               out_pixel_7, out_pixel_8, out_pixel_9,
               out_row, out_col, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 RGB window generator: two line buffers plus per-row column history,
// emitting one registered window per interior pixel, one cycle after the completing pixel.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    window_3x3_if.slave  win
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    // Entries [0]=column c-1, [1]=column c; column c+1 is the live line-buffer read / input.
    logic [DATA_W-1:0] top_q [2], top_d [2];
    logic [DATA_W-1:0] mid_q [2], mid_d [2];
    logic [DATA_W-1:0] bot_q [2], bot_d [2];
    logic [DATA_W-1:0] win_q [9], win_d [9];
    logic [RW-1:0]     orow_q, orow_d;
    logic [CW-1:0]     ocol_q, ocol_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic              completes;

    assign lb0_rd = lb0_q[col_q];
    assign lb1_rd = lb1_q[col_q];

    // The col >= 2 gate also hides column history left over from the previous line.
    assign completes = win.in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        top_d  = top_q;
        mid_d  = mid_q;
        bot_d  = bot_q;
        win_d  = win_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        vld_d  = completes;
        done_d = completes && (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (win.in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            top_d[0] = top_q[1];
            top_d[1] = lb1_rd;
            mid_d[0] = mid_q[1];
            mid_d[1] = lb0_rd;
            bot_d[0] = bot_q[1];
            bot_d[1] = win.in_pixel;
        end
        if (completes) begin
            win_d[0] = top_q[0];
            win_d[1] = top_q[1];
            win_d[2] = lb1_rd;
            win_d[3] = mid_q[0];
            win_d[4] = mid_q[1];
            win_d[5] = lb0_rd;
            win_d[6] = bot_q[0];
            win_d[7] = bot_q[1];
            win_d[8] = win.in_pixel;
            orow_d   = row_q - RW'(1);
            ocol_d   = col_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            orow_q <= '0;
            ocol_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            top_q  <= top_d;
            mid_q  <= mid_d;
            bot_q  <= bot_d;
            win_q  <= win_d;
            orow_q <= orow_d;
            ocol_q <= ocol_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    // Read-before-write: the old LB0 entry ages into LB1 as the new pixel lands in LB0.
    always_ff @(posedge clk) begin
        if (win.in_valid) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= win.in_pixel;
        end
    end

    assign win.out_valid   = vld_q;
    assign win.frame_done  = done_q;
    assign win.out_row     = orow_q;
    assign win.out_col     = ocol_q;
    assign win.out_pixel_1 = win_q[0];
    assign win.out_pixel_2 = win_q[1];
    assign win.out_pixel_3 = win_q[2];
    assign win.out_pixel_4 = win_q[3];
    assign win.out_pixel_5 = win_q[4];
    assign win.out_pixel_6 = win_q[5];
    assign win.out_pixel_7 = win_q[6];
    assign win.out_pixel_8 = win_q[7];
    assign win.out_pixel_9 = win_q[8];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen on a 5x4 image, checked against a
// position-based reference computed from the accepted-pixel index.
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    window_3x3_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(24)) bus ();

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .win   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          acc      = 0;
    int          win_cnt  = 0;
    int          done_cnt = 0;
    logic [23:0] hold_p [9];
    int          hold_row = 0;
    int          hold_col = 0;

    function automatic logic [23:0] pix(int r, int c);
        return {8'(r), 8'(c), 8'(16 * r + c)};
    endfunction

    function automatic logic [23:0] out_pix(int k);
        case (k)
            0: return bus.out_pixel_1;
            1: return bus.out_pixel_2;
            2: return bus.out_pixel_3;
            3: return bus.out_pixel_4;
            4: return bus.out_pixel_5;
            5: return bus.out_pixel_6;
            6: return bus.out_pixel_7;
            7: return bus.out_pixel_8;
            default: return bus.out_pixel_9;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        acc = 0;
        hold_row = 0;
        hold_col = 0;
        for (int k = 0; k < 9; k++) hold_p[k] = '0;
    endtask

    task automatic check_all_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(hold_row * 0));
        check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_row"}, 32'(bus.out_row), 32'(hold_row));
        check({tag, "_col"}, 32'(bus.out_col), 32'(hold_col));
        for (int k = 0; k < 9; k++) check($sformatf("%s_p%0d", tag, k + 1), 32'(out_pix(k)), 32'(hold_p[k]));
    endtask

    // One clock: drive, then compare the DUT against the position-derived expectation.
    task automatic step(input bit v);
        int r, c, cr, cc;
        bit comp;
        r = (acc / W) % H;
        c = acc % W;
        comp = v && (r >= 2) && (c >= 2);
        bus.in_valid = v;
        bus.in_pixel = v ? pix(r, c) : 24'($urandom);
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(comp));
        if (comp) begin
            cr = r - 1;
            cc = c - 1;
            for (int k = 0; k < 9; k++) hold_p[k] = pix(cr - 1 + k / 3, cc - 1 + k % 3);
            hold_row = cr;
            hold_col = cc;
            check("frame_done", 32'(bus.frame_done), 32'((r == H - 1) && (c == W - 1)));
            if (cr == 1 && cc == 1) begin
                check("first_p1", 32'(bus.out_pixel_1), 32'h000000);
                check("first_p5", 32'(bus.out_pixel_5), 32'h010111);
                check("first_p9", 32'(bus.out_pixel_9), 32'h020222);
            end
            if (cr == 2 && cc == 1) begin
                check("c21_p1", 32'(bus.out_pixel_1), 32'h010010);
                check("c21_p3", 32'(bus.out_pixel_3), 32'h010212);
                check("c21_p7", 32'(bus.out_pixel_7), 32'h030030);
            end
            if (cr == 2 && cc == 3) check("last_p9", 32'(bus.out_pixel_9), 32'h030434);
        end else begin
            check("frame_done_idle", 32'(bus.frame_done), 32'd0);
        end
        for (int k = 0; k < 9; k++) check($sformatf("p%0d", k + 1), 32'(out_pix(k)), 32'(hold_p[k]));
        check("out_row", 32'(bus.out_row), 32'(hold_row));
        check("out_col", 32'(bus.out_col), 32'(hold_col));
        if (bus.out_valid) win_cnt++;
        if (bus.frame_done) done_cnt++;
        if (v) acc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = 24'hFFFFFF;
        clear_model();
        #1;
        check_all_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_outputs("rst_hold");
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int start, iter;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        clear_model();
        #2;
        do_reset();

        // Continuous frame
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < W * H; i++) step(1'b1);
        check("cont_windows", 32'(win_cnt), 32'd6);
        check("cont_done", 32'(done_cnt), 32'd1);

        // Frame with random in_valid gaps
        win_cnt = 0; done_cnt = 0;
        start = acc;
        iter = 0;
        while (acc - start < W * H && iter < 400) begin
            step(1'($urandom_range(0, 1)));
            iter++;
        end
        check("gap_frame_complete", 32'(acc - start), 32'(W * H));
        step(1'b0);
        check("gap_windows", 32'(win_cnt), 32'd6);
        check("gap_done", 32'(done_cnt), 32'd1);

        // Two frames back-to-back
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 2 * W * H; i++) step(1'b1);
        check("b2b_windows", 32'(win_cnt), 32'd12);
        check("b2b_done", 32'(done_cnt), 32'd2);

        // Reset mid-frame, then a full clean frame
        for (int i = 0; i < 9; i++) step(1'b1);
        do_reset();
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < W * H; i++) step(1'b1);
        step(1'b0);
        check("rst_windows", 32'(win_cnt), 32'd6);
        check("rst_done", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
